frame_rx_parser: RTL and testbench
==================================

# frame_rx_parser

Byte-stream frame parser that sits directly downstream of `dut_top`, consuming its `txd`/`tx_en` byte stream on the `rxd`/`rx_dv` port pair. It strips the preamble and SFD, removes the 4-byte FCS, and forwards payload bytes with start- and end-of-frame markers. It also checks the CRC32 and keeps frame and error counters.

## Interface
- `MAX_LEN`, 1518: maximum post-SFD bytes (payload + FCS), range 5..65535.
- `PRE_MIN`, 1: minimum count of 0x55 preamble bytes before SFD, range 1..7.
- `clk` in 1: sole clock, 125 MHz, rising edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `rxd` in 8: input byte.
- `rx_dv` in 1: input byte valid, high for the whole frame.
- `out_data` out 8: payload byte.
- `out_valid` out 1: `out_data` valid.
- `out_sop` out 1: first payload byte of a frame.
- `out_eop` out 1: last payload byte of a frame.
- `out_err` out 1: frame status, qualified by `out_eop` (FCS bad or length overflow).
- `frame_cnt` out 16: count of frames ending with `out_eop` and `out_err`=0; saturates at 0xFFFF.
- `err_cnt` out 16: count of errored or dropped frames; saturates at 0xFFFF.

## Operation
- **States:** IDLE, PREAMBLE, DATA, DROP.
- **IDLE:**
  - `rx_dv`=1 with `rxd`=0x55 → PREAMBLE, pre_cnt=1.
  - `rx_dv`=1 with any other byte → DROP, `err_cnt`+1.
- **PREAMBLE:**
  - 0x55 → pre_cnt+1, saturating at 7.
  - 0xD5 with pre_cnt≥`PRE_MIN` → DATA.
  - Any other byte, or 0xD5 with pre_cnt<`PRE_MIN` → DROP, `err_cnt`+1.
  - `rx_dv`=0 → IDLE, `err_cnt`+1.
- **DATA:**
  - Each valid byte shifts into a 5-entry delay line and increments byte_cnt (16 bit).
  - Once 5 bytes are held, each new byte pops the oldest: `out_valid`=1, and `out_sop`=1 for the first pop of the frame.
  - CRC32 (reflected, poly 0x04C11DB7, init 0xFFFFFFFF) is updated over every post-SFD byte, FCS included.
- **End of frame (`rx_dv` falls in DATA):**
  - If byte_cnt≥5, pop the oldest entry (last payload byte) with `out_eop`=1 and `out_err`=(crc≠0xDEBB20E3).
  - If that byte was also the first pop (exactly 5 bytes), `out_sop`=1 too.
  - Discard the remaining 4 FCS bytes.
  - Counters: `frame_cnt`+1 when `out_err`=0, otherwise `err_cnt`+1. Then → IDLE.
  - If byte_cnt<5 (runt): no output, `err_cnt`+1, → IDLE.
- **Overflow:** when byte_cnt would exceed `MAX_LEN`, pop the oldest entry with `out_eop`=1, `out_err`=1, `err_cnt`+1, then → DROP.
- **DROP:** ignores all bytes and returns to IDLE on the first `rx_dv`=0 cycle.
- **Gaps:** a one-cycle `rx_dv` gap between frames is sufficient. The cycle in which `rx_dv`=0 is the end-of-frame cycle, and the next `rx_dv`=1 is parsed from IDLE.

## Timing
- **Registered outputs:** all outputs are registered. An output event caused by an input sample at edge N is visible after edge N.
- **Payload latency:** payload byte k appears 5 valid input cycles after it was sampled.
- **EOP timing:** `out_eop` appears the cycle after the first `rx_dv`=0 sample.
- **Output strobe gating:** `out_sop`, `out_eop` and `out_err` are only ever high with `out_valid`=1. `out_err` is 0 whenever `out_eop`=0.
- **Reset values:**
  - State IDLE.
  - `out_data`=0x00, `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_err`=0.
  - `frame_cnt`=0, `err_cnt`=0.
  - Delay line empty, crc=0xFFFFFFFF.
- **Reset mid-frame:** no `out_eop` is emitted for the aborted frame and no counter increments. The next frame must start with a fresh preamble.
- **No backpressure:** the consumer must accept one byte per cycle.

## Configuration
- `FRAME_RX_CRC_CHECK_EN` defined: CRC32 logic is present, and `out_err` reflects FCS mismatch or overflow.
- `FRAME_RX_CRC_CHECK_EN` undefined: CRC logic is removed, and `out_err` reflects only overflow. FCS stripping and the 5-byte latency are unchanged.

## Structure
- **Package `frame_rx_pkg`:**
  - State enum `frame_rx_state_e`.
  - Constants `PREAMBLE_BYTE`=8'h55, `SFD_BYTE`=8'hD5, `CRC_INIT`=32'hFFFFFFFF, `CRC_RESIDUE`=32'hDEBB20E3, `FCS_LEN`=4.
  - Byte-wise function `crc32_next(crc, byte)`.
- **Sub-module `frame_rx_crc32`:** holds the registered CRC accumulator, with clear and enable inputs. It is instantiated only under `FRAME_RX_CRC_CHECK_EN`.

## Test plan
- **Good frame:** 7×0x55, 0xD5, payload 0x00..0x2D (46 bytes), correct FCS → 46 `out_valid` beats; `out_sop` on 0x00; `out_eop` on 0x2D with `out_err`=0; `frame_cnt`=1, `err_cnt`=0.
- **Bad FCS:** same frame with the last FCS byte XOR 0x01 → 46 beats, `out_eop` with `out_err`=1, `err_cnt`=1. With the macro undefined: `out_err`=0 and `frame_cnt`=1.
- **Bad preamble and runt:**
  - 0x55, 0x54, … → no output, DROP until `rx_dv` low, `err_cnt`+1.
  - 0x55, 0xD5, then 3 bytes → no output, `err_cnt`+1.
- **Back-to-back:** two good 60-byte frames separated by a 1-cycle `rx_dv` gap → two complete sop..eop sequences of 56 beats each, `frame_cnt`=2.
- **Overflow and reset mid-frame:**
  - `MAX_LEN`=64 with a 100-byte frame → `out_eop`+`out_err` after the 60th payload beat, nothing further, `err_cnt`=1.
  - `rst` asserted after 10 payload beats → outputs 0, counters 0; the following good frame parses correctly.

Source files
------------

// File: rtl/frame_rx_pkg.sv
// frame_rx_pkg: shared types, constants and helpers for the frame receive parser.
//   frame_rx_state_e : parser FSM states
//   crc32_next       : one-byte update of the reflected CRC32 (poly 0x04C11DB7)
//   sat_inc16        : saturating 16-bit increment for the frame/error counters
package frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } frame_rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam int          FCS_LEN       = 4;
    // One extra slot so the last payload byte is still held when rx_dv drops.
    localparam int          DLY_LEN       = FCS_LEN + 1;

    // LSB-first CRC32; 0xEDB88320 is the bit-reversed form of 0x04C11DB7.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_rx_parser_if.sv
// frame_rx_parser_if: byte-stream input and parsed-payload output of the parser.
//   rxd/rx_dv           : incoming byte stream (driven by master)
//   out_data/out_valid  : payload byte stream, one byte per cycle, no backpressure
//   out_sop/out_eop     : first/last payload byte of a frame
//   out_err             : frame status, meaningful only with out_eop
//   frame_cnt/err_cnt   : saturating good / errored-or-dropped frame counters
interface frame_rx_parser_if;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    modport master (
        output rxd, rx_dv,
        input  out_data, out_valid, out_sop, out_eop, out_err, frame_cnt, err_cnt
    );

    modport slave (
        input  rxd, rx_dv,
        output out_data, out_valid, out_sop, out_eop, out_err, frame_cnt, err_cnt
    );
endinterface

// File: rtl/frame_rx_crc32.sv
// frame_rx_crc32: registered CRC32 accumulator.
//   clk, rst : clock, synchronous active-high reset
//   clr      : reload CRC_INIT (takes priority over en)
//   en, data : fold one byte into the accumulator
//   crc      : current accumulator value (no final inversion)
module frame_rx_crc32
    import frame_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_next(crc, data);
        end
    end

endmodule

// File: rtl/frame_rx_parser.sv
// frame_rx_parser: strips preamble/SFD and FCS from a byte stream, forwards the
// payload with sop/eop markers, and keeps good/error frame counters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : frame_rx_parser_if.slave (rxd/rx_dv in, out_* and counters out)
// Parameters: MAX_LEN (max post-SFD bytes incl. FCS), PRE_MIN (min 0x55 count).
// Build option: define FRAME_RX_CRC_CHECK_EN to check the FCS; without it
// out_err only flags length overflow.
module frame_rx_parser
    import frame_rx_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned PRE_MIN = 1
) (
    input  logic             clk,
    input  logic             rst,
    frame_rx_parser_if.slave bus
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_LEN);
    localparam logic [2:0]  PRE_THR = 3'(PRE_MIN);

    frame_rx_state_e          state;
    logic [2:0]               pre_cnt;
    logic [15:0]              byte_cnt;
    logic [DLY_LEN-1:0][7:0]  dly;       // dly[0] newest, dly[DLY_LEN-1] oldest
    logic [7:0]               out_data_q;
    logic                     out_valid_q, out_sop_q, out_eop_q, out_err_q;
    logic [15:0]              frame_cnt_q, err_cnt_q;
    logic                     held, first_pop, crc_bad;

    // Delay line is full once DLY_LEN bytes are in; the pop at exactly that
    // count is the first payload byte of the frame.
    assign held      = (byte_cnt >= 16'(DLY_LEN));
    assign first_pop = (byte_cnt == 16'(DLY_LEN));

`ifdef FRAME_RX_CRC_CHECK_EN
    logic [31:0] crc;

    // Accumulator is reset while outside DATA, so it starts fresh at the SFD.
    frame_rx_crc32 u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != DATA),
        .en   ((state == DATA) && bus.rx_dv),
        .data (bus.rxd),
        .crc  (crc)
    );

    assign crc_bad = (crc != CRC_RESIDUE);
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pre_cnt     <= '0;
            byte_cnt    <= '0;
            dly         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.rx_dv) begin
                        if (bus.rxd == PREAMBLE_BYTE) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state     <= DROP;
                            err_cnt_q <= sat_inc16(err_cnt_q);
                        end
                    end
                end

                PREAMBLE: begin
                    if (!bus.rx_dv) begin
                        state     <= IDLE;
                        err_cnt_q <= sat_inc16(err_cnt_q);
                    end else if (bus.rxd == PREAMBLE_BYTE) begin
                        if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
                    end else if (bus.rxd == SFD_BYTE && pre_cnt >= PRE_THR) begin
                        state    <= DATA;
                        byte_cnt <= '0;
                    end else begin
                        state     <= DROP;
                        err_cnt_q <= sat_inc16(err_cnt_q);
                    end
                end

                DATA: begin
                    if (bus.rx_dv) begin
                        if (byte_cnt == MAX_CNT) begin
                            // Too long: close the frame now with an error.
                            out_valid_q <= 1'b1;
                            out_data_q  <= dly[DLY_LEN-1];
                            out_sop_q   <= first_pop;
                            out_eop_q   <= 1'b1;
                            out_err_q   <= 1'b1;
                            err_cnt_q   <= sat_inc16(err_cnt_q);
                            state       <= DROP;
                        end else begin
                            dly      <= {dly[DLY_LEN-2:0], bus.rxd};
                            byte_cnt <= byte_cnt + 16'd1;
                            if (held) begin
                                out_valid_q <= 1'b1;
                                out_data_q  <= dly[DLY_LEN-1];
                                out_sop_q   <= first_pop;
                            end
                        end
                    end else begin
                        // End of frame: oldest entry is the last payload byte,
                        // the other FCS_LEN entries are the FCS and are dropped.
                        if (held) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= dly[DLY_LEN-1];
                            out_sop_q   <= first_pop;
                            out_eop_q   <= 1'b1;
                            out_err_q   <= crc_bad;
                            if (crc_bad) err_cnt_q   <= sat_inc16(err_cnt_q);
                            else         frame_cnt_q <= sat_inc16(frame_cnt_q);
                        end else begin
                            err_cnt_q <= sat_inc16(err_cnt_q);
                        end
                        state <= IDLE;
                    end
                end

                DROP: begin
                    if (!bus.rx_dv) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_err   = out_err_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_frame_rx_parser.sv
// tb_frame_rx_parser: directed + randomized frames against a frame-level model.
// The model treats each rx_dv burst as a whole: it classifies the burst,
// computes which payload bytes must appear, at which cycle, and with what status.
module tb_frame_rx_parser;

    localparam int MAX_LEN = 64;
    localparam int PRE_MIN = 2;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
        int         cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   exp_frames = 0;
    int   exp_errs = 0;
    beat_t got_q[$];
    beat_t exp_q[$];

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_rx_parser_if bus ();

    frame_rx_parser #(.MAX_LEN(MAX_LEN), .PRE_MIN(PRE_MIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: capture every beat with its cycle; strobes must never
    // appear without out_valid, and out_err never without out_eop.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1)
            got_q.push_back('{bus.out_data, bus.out_sop, bus.out_eop, bus.out_err, cyc});
        chk("strobe_gate", {28'h0, ~bus.out_valid & bus.out_sop, ~bus.out_valid & bus.out_eop,
                            ~bus.out_valid & bus.out_err, bus.out_err & ~bus.out_eop}, 32'h0);
    end

    // Standard Ethernet FCS of the first n bytes (final inversion applied).
    function automatic logic [31:0] fcs_of(input bq_t q, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t mk_frame(input int npre, input bq_t pay, input bit bad_fcs);
        bq_t f;
        logic [31:0] c;
        for (int i = 0; i < npre; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        foreach (pay[i]) f.push_back(pay[i]);
        c = fcs_of(pay, pay.size());
        f.push_back(c[7:0]);
        f.push_back(c[15:8]);
        f.push_back(c[23:16]);
        f.push_back(c[31:24] ^ (bad_fcs ? 8'h01 : 8'h00));
        return f;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Frame-level reference: burst b, first byte driven when cyc == s.
    task automatic model_burst(input bq_t b, input int s);
        int   n, p, len, nb, last_cyc;
        bit   bad;
        bq_t  post;
        logic [31:0] c;
        n = 0;
        while (n < b.size() && b[n] == 8'h55) n++;
        if (n == 0 || n == b.size() || b[n] != 8'hD5 || n < PRE_MIN) begin
            exp_errs++;
            return;
        end
        p = n + 1;
        for (int i = p; i < b.size(); i++) post.push_back(b[i]);
        len = post.size();
        if (len > MAX_LEN) begin
            nb = MAX_LEN - 4;
            bad = 1'b1;
            last_cyc = s + p + MAX_LEN + 1;
        end else if (len < 5) begin
            exp_errs++;
            return;
        end else begin
            nb = len - 4;
            last_cyc = s + b.size() + 1;
`ifdef FRAME_RX_CRC_CHECK_EN
            c = fcs_of(post, len - 4);
            bad = ({post[len-1], post[len-2], post[len-3], post[len-4]} != c);
`else
            c = 32'h0;
            bad = 1'b0;
`endif
        end
        for (int j = 0; j < nb; j++)
            exp_q.push_back('{post[j], (j == 0), (j == nb - 1), (j == nb - 1) && bad,
                              (j == nb - 1) ? last_cyc : s + p + j + 6});
        if (bad) exp_errs++;
        else     exp_frames++;
    endtask

    // Drive one rx_dv burst followed by a single idle cycle.
    task automatic send(input bq_t b);
        int s;
        s = 0;
        for (int i = 0; i < b.size(); i++) begin
            @(negedge clk);
            if (i == 0) s = cyc;
            bus.rx_dv = 1'b1;
            bus.rxd   = b[i];
        end
        @(negedge clk);
        bus.rx_dv = 1'b0;
        bus.rxd   = 8'h00;
        model_burst(b, s);
    endtask

    task automatic check_group(input string tag);
        int n;
        repeat (8) @(negedge clk);
        chk({tag, "_nbeats"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_beat%0d{cyc,sop,eop,err,data}", tag, i),
                {20'(got_q[i].cyc), 1'b0, got_q[i].sop, got_q[i].eop, got_q[i].err, got_q[i].data},
                {20'(exp_q[i].cyc), 1'b0, exp_q[i].sop, exp_q[i].eop, exp_q[i].err, exp_q[i].data});
        chk({tag, "_frame_cnt"}, bus.frame_cnt, 32'(exp_frames));
        chk({tag, "_err_cnt"}, bus.err_cnt, 32'(exp_errs));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bq_t pay, f, f2;
        int  s;
        rst = 1'b1;
        bus.rx_dv = 1'b0;
        bus.rxd = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_out", {27'h0, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_err, 1'b0}, 32'h0);
        chk("reset_data", bus.out_data, 32'h0);
        chk("reset_cnts", {bus.frame_cnt, bus.err_cnt}, 32'h0);
        rst = 1'b0;

        // Good frame: 46-byte payload 0x00..0x2D.
        pay.delete();
        for (int i = 0; i < 46; i++) pay.push_back(8'(i));
        send(mk_frame(7, pay, 1'b0));
        check_group("good");

        // Same frame, last FCS byte flipped.
        send(mk_frame(7, pay, 1'b1));
        check_group("bad_fcs");

        // Preamble errors and runts.
        f = '{8'h55, 8'h54, 8'h55, 8'hD5, 8'h01, 8'h02};
        send(f);
        f = '{8'h55, 8'h55, 8'hD5, 8'h11, 8'h22, 8'h33};
        send(f);
        f = '{8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send(f);
        f = '{8'hAA, 8'h55, 8'hD5};
        send(f);
        f = '{8'h55, 8'h55, 8'h55};
        send(f);
        f = '{8'h55, 8'h55, 8'hD5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send(f);
        check_group("preamble_runt");

        // Back-to-back 60-byte frames with a single idle cycle between.
        send(mk_frame(7, rand_bytes(56), 1'b0));
        send(mk_frame(7, rand_bytes(56), 1'b0));
        check_group("b2b");

        // 100 post-SFD bytes against MAX_LEN=64.
        f = '{8'h55, 8'h55, 8'h55, 8'hD5};
        f2 = rand_bytes(100);
        foreach (f2[i]) f.push_back(f2[i]);
        send(f);
        check_group("overflow");

        // Length boundary: exactly MAX_LEN, then MAX_LEN+1.
        send(mk_frame(3, rand_bytes(MAX_LEN - 4), 1'b0));
        send(mk_frame(3, rand_bytes(MAX_LEN - 3), 1'b0));
        check_group("len_edge");

        // Randomized mix.
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                f = rand_bytes($urandom_range(1, 8));
                if (f[0] == 8'h55) f[0] = 8'h00;
            end else if (kind == 1) begin
                f = '{8'h55, 8'h55};
                f.push_back((8'($urandom) == 8'h55) ? 8'h00 : 8'h3C);
                f2 = rand_bytes($urandom_range(0, 6));
                foreach (f2[i]) f.push_back(f2[i]);
            end else begin
                f = mk_frame($urandom_range(1, 9), rand_bytes($urandom_range(0, 66)),
                             ($urandom_range(0, 3) == 0));
            end
            send(f);
            if (it % 10 == 9) check_group($sformatf("rand%0d", it / 10));
        end

        // Reset after 10 payload beats of a frame.
        f = mk_frame(2, rand_bytes(20), 1'b0);
        s = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) s = cyc;
            bus.rx_dv = 1'b1;
            bus.rxd   = f[i];
        end
        for (int j = 0; j < 10; j++)
            exp_q.push_back('{f[3 + j], (j == 0), 1'b0, 1'b0, s + 3 + j + 6});
        @(negedge clk);
        bus.rx_dv = 1'b0;
        bus.rxd   = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_mid_data", bus.out_data, 32'h0);
        exp_frames = 0;
        exp_errs = 0;
        check_group("rst_mid");
        send(mk_frame(7, rand_bytes(30), 1'b0));
        check_group("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
